// File: rtl/ibex_rvfi_trace_checker_pkg.sv
// Shared types for the RVFI retirement trace checker: checker state,
// expected-record layout and mismatch-mask bit positions.
package ibex_rvfi_trace_checker_pkg;

    typedef enum logic [1:0] {
        TRACE_CHK_IDLE = 2'd0,
        TRACE_CHK_RUN  = 2'd1,
        TRACE_CHK_FAIL = 2'd2,
        TRACE_CHK_DONE = 2'd3
    } trace_chk_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        last;
    } trace_rec_t;

    localparam int unsigned TRACE_MISMATCH_PC        = 0;
    localparam int unsigned TRACE_MISMATCH_INSN      = 1;
    localparam int unsigned TRACE_MISMATCH_RD_ADDR   = 2;
    localparam int unsigned TRACE_MISMATCH_RD_WDATA  = 3;
    localparam int unsigned TRACE_MISMATCH_UNDERFLOW = 4;
    localparam int unsigned TRACE_MISMATCH_W         = 5;

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Small synchronous FIFO of expected trace records. The head is read
// combinationally so a retirement can pop and compare in the same cycle.
module ibex_trace_rec_fifo
    import ibex_rvfi_trace_checker_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  trace_rec_t wdata_i,
    input  logic       pop_i,
    output trace_rec_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    trace_rec_t       mem_reg [Depth];
    logic [PtrW:0]    wr_ptr_reg;
    logic [PtrW:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                     (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_reg[rd_ptr_reg[PtrW-1:0]];

    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_reg[PtrW-1:0] == PtrW'(gi))) begin
                mem_reg[gi] <= wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_checker.sv
// Compares live RVFI retirements against a stream of expected records and
// reports the first mismatch, completion and a saturating match count.
module ibex_rvfi_trace_checker
    import ibex_rvfi_trace_checker_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter bit          SkipTraps = 1'b1,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        exp_valid_i,
    output logic                        exp_ready_o,
    input  logic [31:0]                 exp_pc_i,
    input  logic [31:0]                 exp_insn_i,
    input  logic [4:0]                  exp_rd_addr_i,
    input  logic [31:0]                 exp_rd_wdata_i,
    input  logic                        exp_last_i,
    input  logic                        rvfi_valid_i,
    input  logic                        rvfi_trap_i,
    input  logic [31:0]                 rvfi_pc_rdata_i,
    input  logic [31:0]                 rvfi_insn_i,
    input  logic [4:0]                  rvfi_rd_addr_i,
    input  logic [31:0]                 rvfi_rd_wdata_i,
    output logic                        mismatch_o,
    output logic [TRACE_MISMATCH_W-1:0] mismatch_mask_o,
    output logic [31:0]                 fail_pc_o,
    output logic                        done_o,
    output logic [CntWidth-1:0]         match_count_o
);

    trace_chk_state_e            state_reg, state_next;
    logic                        mismatch_reg, mismatch_next;
    logic [TRACE_MISMATCH_W-1:0] mask_reg, mask_next;
    logic [31:0]                 fail_pc_reg, fail_pc_next;
    logic                        done_reg, done_next;
    logic [CntWidth-1:0]         count_reg, count_next;

    trace_rec_t                  push_rec;
    trace_rec_t                  head_rec;
    logic                        fifo_full, fifo_empty;
    logic                        push, retire, underflow, pop, cmp_fail;
    logic [TRACE_MISMATCH_W-1:0] cmp_mask;

    assign push_rec = '{pc: exp_pc_i, insn: exp_insn_i, rd_addr: exp_rd_addr_i,
                        rd_wdata: exp_rd_wdata_i, last: exp_last_i};

    // Ready is held low while reset is asserted, not only after the first edge.
    assign exp_ready_o = rst_ni && !fifo_full &&
                         (state_reg == TRACE_CHK_RUN || state_reg == TRACE_CHK_IDLE);
    assign push        = exp_valid_i && exp_ready_o;

    assign retire    = (state_reg == TRACE_CHK_RUN) && rvfi_valid_i &&
                       !(SkipTraps && rvfi_trap_i);
    assign underflow = retire && fifo_empty;
    assign pop       = retire && !fifo_empty;

    always_comb begin
        cmp_mask = '0;
        cmp_mask[TRACE_MISMATCH_PC]       = head_rec.pc != rvfi_pc_rdata_i;
        cmp_mask[TRACE_MISMATCH_INSN]     = head_rec.insn != rvfi_insn_i;
        cmp_mask[TRACE_MISMATCH_RD_ADDR]  = head_rec.rd_addr != rvfi_rd_addr_i;
        // Writes to x0 are architecturally discarded, so their data is don't-care.
        cmp_mask[TRACE_MISMATCH_RD_WDATA] = (head_rec.rd_addr != 5'd0) &&
                                            (head_rec.rd_wdata != rvfi_rd_wdata_i);
    end

    assign cmp_fail = pop && (cmp_mask != '0);

    ibex_trace_rec_fifo #(
        .Depth (Depth)
    ) u_rec_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_next    = state_reg;
        mismatch_next = mismatch_reg;
        mask_next     = mask_reg;
        fail_pc_next  = fail_pc_reg;
        done_next     = done_reg;
        count_next    = count_reg;
        unique case (state_reg)
            TRACE_CHK_IDLE: begin
                if (enable_i) state_next = TRACE_CHK_RUN;
            end
            TRACE_CHK_RUN: begin
                if (underflow || cmp_fail) begin
                    state_next    = TRACE_CHK_FAIL;
                    mismatch_next = 1'b1;
                    mask_next     = underflow ? TRACE_MISMATCH_W'(1 << TRACE_MISMATCH_UNDERFLOW)
                                              : cmp_mask;
                    fail_pc_next  = rvfi_pc_rdata_i;
                end else begin
                    if (pop) begin
                        if (count_reg != '1) count_next = count_reg + 1'b1;
                        if (head_rec.last) begin
                            state_next = TRACE_CHK_DONE;
                            done_next  = 1'b1;
                        end
                    end
                    if (state_next == TRACE_CHK_RUN && !enable_i) state_next = TRACE_CHK_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= TRACE_CHK_IDLE;
            mismatch_reg <= 1'b0;
            mask_reg     <= '0;
            fail_pc_reg  <= '0;
            done_reg     <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            mismatch_reg <= mismatch_next;
            mask_reg     <= mask_next;
            fail_pc_reg  <= fail_pc_next;
            done_reg     <= done_next;
            count_reg    <= count_next;
        end
    end

    assign mismatch_o      = mismatch_reg;
    assign mismatch_mask_o = mask_reg;
    assign fail_pc_o       = fail_pc_reg;
    assign done_o          = done_reg;
    assign match_count_o   = count_reg;

endmodule

// File: tb/tb_ibex_rvfi_trace_checker.sv
// Scoreboard bench for the RVFI trace checker: a behavioural model predicts
// the registered outputs for every cycle, which are checked after the edge.
module tb_ibex_rvfi_trace_checker;
    import ibex_rvfi_trace_checker_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk_i, rst_ni, enable_i;
    logic          exp_valid_i, exp_ready_o, exp_last_i;
    logic [31:0]   exp_pc_i, exp_insn_i, exp_rd_wdata_i;
    logic [4:0]    exp_rd_addr_i;
    logic          rvfi_valid_i, rvfi_trap_i;
    logic [31:0]   rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i;
    logic [4:0]    rvfi_rd_addr_i;
    logic          mismatch_o, done_o;
    logic [4:0]    mismatch_mask_o;
    logic [31:0]   fail_pc_o;
    logic [CW-1:0] match_count_o;

    ibex_rvfi_trace_checker #(.Depth(DEPTH), .SkipTraps(1'b1), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
        .exp_pc_i(exp_pc_i), .exp_insn_i(exp_insn_i), .exp_rd_addr_i(exp_rd_addr_i),
        .exp_rd_wdata_i(exp_rd_wdata_i), .exp_last_i(exp_last_i),
        .rvfi_valid_i(rvfi_valid_i), .rvfi_trap_i(rvfi_trap_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
        .mismatch_o(mismatch_o), .mismatch_mask_o(mismatch_mask_o), .fail_pc_o(fail_pc_o),
        .done_o(done_o), .match_count_o(match_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit            mis;
        logic [4:0]    mask;
        logic [31:0]   fpc;
        bit            done;
        logic [CW-1:0] cnt;
    } snap_t;

    int            checks = 0;
    int            errors = 0;
    snap_t         sb[$];
    trace_rec_t    m_fifo[$];
    int            m_state;  // 0 idle, 1 run, 2 fail, 3 done
    snap_t         m_out;
    trace_rec_t    nul_rec;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic trace_rec_t mk_rec(input logic [31:0] pc, input logic [31:0] insn,
                                          input logic [4:0] rd, input logic [31:0] wd,
                                          input logic last);
        trace_rec_t r;
        r.pc = pc; r.insn = insn; r.rd_addr = rd; r.rd_wdata = wd; r.last = last;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input snap_t s);
        check_val({tag, "_mismatch"}, 32'(mismatch_o), 32'(s.mis));
        check_val({tag, "_mask"}, 32'(mismatch_mask_o), 32'(s.mask));
        check_val({tag, "_fail_pc"}, fail_pc_o, s.fpc);
        check_val({tag, "_done"}, 32'(done_o), 32'(s.done));
        check_val({tag, "_count"}, 32'(match_count_o), 32'(s.cnt));
    endtask

    task automatic drive_idle();
        exp_valid_i = 0; exp_pc_i = 0; exp_insn_i = 0; exp_rd_addr_i = 0;
        exp_rd_wdata_i = 0; exp_last_i = 0;
        rvfi_valid_i = 0; rvfi_trap_i = 0; rvfi_pc_rdata_i = 0; rvfi_insn_i = 0;
        rvfi_rd_addr_i = 0; rvfi_rd_wdata_i = 0;
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        snap_t z;
        z = '{mis: 0, mask: '0, fpc: '0, done: 0, cnt: '0};
        #1 rst_ni = 1'b0;
        enable_i = 1'b0;
        drive_idle();
        #1;
        check_outputs("reset", z);
        check_val("reset_ready", 32'(exp_ready_o), 32'd0);
        m_fifo.delete();
        sb.delete();
        m_state = 0;
        m_out = z;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // One clock cycle of stimulus; model predicts outputs, queued and checked after the edge.
    task automatic step(input bit en, input bit push, input trace_rec_t prec,
                        input bit ret, input bit trap, input trace_rec_t rrec, output bit acc);
        bit         m_ready;
        trace_rec_t h;
        logic [4:0] mk;
        snap_t      s;
        enable_i = en;
        exp_valid_i = push; exp_pc_i = prec.pc; exp_insn_i = prec.insn;
        exp_rd_addr_i = prec.rd_addr; exp_rd_wdata_i = prec.rd_wdata; exp_last_i = prec.last;
        rvfi_valid_i = ret; rvfi_trap_i = trap; rvfi_pc_rdata_i = rrec.pc;
        rvfi_insn_i = rrec.insn; rvfi_rd_addr_i = rrec.rd_addr; rvfi_rd_wdata_i = rrec.rd_wdata;
        #3;
        m_ready = (m_state == 0 || m_state == 1) && (m_fifo.size() < DEPTH);
        check_val("exp_ready", 32'(exp_ready_o), 32'(m_ready));
        acc = push && m_ready;
        if (m_state == 1) begin
            if (ret && !trap) begin
                if (m_fifo.size() == 0) begin
                    m_state = 2; m_out.mis = 1; m_out.mask = 5'b10000; m_out.fpc = rrec.pc;
                end else begin
                    h = m_fifo.pop_front();
                    mk = 5'b0;
                    mk[0] = h.pc != rrec.pc;
                    mk[1] = h.insn != rrec.insn;
                    mk[2] = h.rd_addr != rrec.rd_addr;
                    mk[3] = (h.rd_addr != 0) && (h.rd_wdata != rrec.rd_wdata);
                    if (mk != 0) begin
                        m_state = 2; m_out.mis = 1; m_out.mask = mk; m_out.fpc = rrec.pc;
                    end else begin
                        if (m_out.cnt != {CW{1'b1}}) m_out.cnt = m_out.cnt + 1'b1;
                        if (h.last) begin m_state = 3; m_out.done = 1; end
                    end
                end
            end
            if (m_state == 1 && !en) m_state = 0;
        end else if (m_state == 0 && en) begin
            m_state = 1;
        end
        if (acc) m_fifo.push_back(prec);
        sb.push_back(m_out);
        @(posedge clk_i); #1;
        s = sb.pop_front();
        $display("cycle en=%0b push=%0b acc=%0b ret=%0b trap=%0b pc=%h -> mis=%0b mask=%b done=%0b cnt=%0d",
                 en, push, acc, ret, trap, rrec.pc, mismatch_o, mismatch_mask_o, done_o, match_count_o);
        check_outputs("cycle", s);
        drive_idle();
    endtask

    task automatic push_rec(input bit en, input trace_rec_t r);
        bit acc;
        acc = 0;
        for (int i = 0; i < 8 && !acc; i++) step(en, 1, r, 0, 0, nul_rec, acc);
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout pc=%h never accepted", r.pc);
        end
    endtask

    task automatic retire(input trace_rec_t r, input bit trap);
        bit acc;
        step(1, 0, nul_rec, 1, trap, r, acc);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        trace_rec_t r0, r1, r2, r3, r4, rb;
        trace_rec_t recs[10];
        bit acc;
        int ip, ir;
        nul_rec = mk_rec(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        enable_i = 1'b0;
        drive_idle();

        // Three matching retirements ending on the last record
        do_reset();
        r0 = mk_rec(32'h100, 32'h0050_0293, 5'd5, 32'h5, 0);
        r1 = mk_rec(32'h104, 32'h0060_0313, 5'd6, 32'h6, 0);
        r2 = mk_rec(32'h108, 32'h0070_0393, 5'd7, 32'h7, 1);
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        push_rec(1, r0); push_rec(1, r1); push_rec(1, r2);
        retire(r0, 0); retire(r1, 0); retire(r2, 0);
        check_val("t1_count", 32'(match_count_o), 32'd3);
        check_val("t1_done", 32'(done_o), 32'd1);
        check_val("t1_mismatch", 32'(mismatch_o), 32'd0);

        // rd_wdata mismatch on the second retirement; later retirements ignored
        do_reset();
        r1 = mk_rec(32'h104, 32'h0060_0293, 5'd5, 32'hBEEF, 0);
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        push_rec(1, r0); push_rec(1, r1); push_rec(1, r2);
        retire(r0, 0);
        rb = r1; rb.rd_wdata = 32'hDEAD;
        retire(rb, 0);
        retire(r2, 0);
        check_val("t2_mask", 32'(mismatch_mask_o), 32'h08);
        check_val("t2_fail_pc", fail_pc_o, 32'h104);
        check_val("t2_count", 32'(match_count_o), 32'd1);

        // Reset mid-stream with a leftover record, then retire while pushing: underflow
        do_reset();
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        step(1, 1, r0, 1, 0, r0, acc);
        check_val("t4_mask", 32'(mismatch_mask_o), 32'h10);
        check_val("t4_fail_pc", fail_pc_o, 32'h100);

        // Expected rd=x0 ignores write data
        do_reset();
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        r3 = mk_rec(32'h200, 32'h0000_0013, 5'd0, 32'h11, 0);
        push_rec(1, r3);
        rb = r3; rb.rd_wdata = 32'h22;
        retire(rb, 0);
        check_val("t3_count", 32'(match_count_o), 32'd1);

        // Full FIFO: push stalls while full even with a pop in the same cycle
        do_reset();
        r0 = mk_rec(32'h300, 32'h11, 5'd1, 32'hA0, 0);
        r1 = mk_rec(32'h304, 32'h12, 5'd2, 32'hA1, 0);
        r2 = mk_rec(32'h308, 32'h13, 5'd3, 32'hA2, 0);
        r3 = mk_rec(32'h30C, 32'h14, 5'd4, 32'hA3, 0);
        r4 = mk_rec(32'h310, 32'h15, 5'd5, 32'hA4, 1);
        push_rec(0, r0); push_rec(0, r1); push_rec(0, r2); push_rec(0, r3);
        step(1, 1, r4, 0, 0, nul_rec, acc);
        check_val("t5_full_stall0", 32'(acc), 32'd0);
        step(1, 1, r4, 1, 0, r0, acc);
        check_val("t5_full_stall1", 32'(acc), 32'd0);
        step(1, 1, r4, 1, 0, r1, acc);
        check_val("t5_push_after", 32'(acc), 32'd1);
        retire(r2, 0); retire(r3, 0); retire(r4, 0);
        check_val("t5_count", 32'(match_count_o), 32'd5);
        check_val("t5_done", 32'(done_o), 32'd1);

        // Trapped retirement is skipped
        do_reset();
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        push_rec(1, r0); push_rec(1, r1);
        retire(mk_rec(32'h900, 32'h0, 5'd0, 32'h0, 0), 1);
        check_val("t6_trap_count", 32'(match_count_o), 32'd0);
        retire(r0, 0);
        check_val("t6_count", 32'(match_count_o), 32'd1);

        // Back-to-back retirements with concurrent pushes; count saturates
        do_reset();
        for (int i = 0; i < 10; i++)
            recs[i] = mk_rec(32'h400 + 32'(i * 4), 32'h100 + 32'(i), 5'(i + 1),
                             32'hC0 + 32'(i), i == 9);
        step(1, 0, nul_rec, 0, 0, nul_rec, acc);
        ip = 0; ir = 0;
        for (int c = 0; c < 40 && ir < 10; c++) begin
            bit do_ret;
            do_ret = m_fifo.size() > 0;
            step(1, ip < 10, (ip < 10) ? recs[ip] : nul_rec, do_ret, 0,
                 do_ret ? recs[ir] : nul_rec, acc);
            if (acc) ip++;
            if (do_ret) ir++;
        end
        check_val("t7_sat_count", 32'(match_count_o), 32'd7);
        check_val("t7_done", 32'(done_o), 32'd1);
        check_val("t7_mismatch", 32'(mismatch_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
